traffic_ctrl_multi: RTL and testbench
=====================================

// Module: traffic_ctrl_multi
// PURPOSE
// - N-direction generalisation of the two-road Ta/Tb, La/Lb light controller.
// - Grants green to one direction at a time. Each green is bounded by min/max hold times.
// - Every change of direction passes through YELLOW then ALL-RED.
// - Next direction is picked round-robin among directions with traffic demand.
// - Emergency pre-emption input. Sits at top level, driving lamp drivers from debounced road sensors.
// PARAMETERS
// - N_DIR          3   number of directions, 2..8
// - MIN_GREEN_CYC  4   minimum green cycles before a demand-driven switch, >=1
// - MAX_GREEN_CYC  8   green cycles after which a still-busy direction yields, >=MIN_GREEN_CYC
// - YELLOW_CYC     2   exact YELLOW duration, >=1
// - ALL_RED_CYC    1   exact ALL_RED duration, >=1
// - Derived localparams (not overridable): DIR_W=$clog2(N_DIR); CNT_W sized to hold max(MAX_GREEN_CYC,YELLOW_CYC,ALL_RED_CYC).
// PORTS
// - clk          in   1              single clock, all state on posedge
// - rst          in   1              synchronous, active-high reset
// - traffic      in   N_DIR          per-direction demand sensor, 1 = vehicles waiting
// - emer_valid   in   1              emergency pre-emption request, level
// - emer_dir     in   DIR_W          direction requested by emergency
// - lights       out  N_DIR x 2      packed, light_t per direction
// - cur_dir      out  DIR_W          direction owning the current/last green
// - switch_pulse out  1              1-cycle high on first cycle of each new green
// BEHAVIOUR
// - Moore machine. All outputs decode from registered state; no input-to-output combinational path.
// - States: GREEN, YELLOW, ALL_RED. Counter cnt is cleared on every state entry and saturates at MAX_GREEN_CYC-1.
// - Reset values: state=GREEN, cur_dir=0, cnt=0, target=0, switch_pulse=0.
//   - lights: dir0 GREEN, all others RED.
//   - rst mid-phase returns to this on the next edge.
// - Lights:
//   - GREEN: lights[cur_dir]=GREEN.
//   - YELLOW: lights[cur_dir]=YELLOW.
//   - ALL_RED: all directions RED.
//   - Non-current directions are always RED.
// - pick = first index after cur_dir, wrapping modulo N_DIR, with traffic=1, excluding cur_dir. other = any such index exists.
// - emer_ok = emer_valid && emer_dir<N_DIR. If emer_dir>=N_DIR, the request is ignored entirely.
// - GREEN, per cycle, in priority order:
//   1. emer_ok && emer_dir==cur_dir: stay GREEN, max limit suspended.
//   2. emer_ok && emer_dir!=cur_dir: target<=emer_dir, go YELLOW immediately (min green ignored).
//   3. other && cnt>=MIN_GREEN_CYC-1 && (!traffic[cur_dir] || cnt>=MAX_GREEN_CYC-1): target<=pick, go YELLOW.
//   4. Otherwise stay GREEN. With no other demand, green holds indefinitely.
// - YELLOW: exactly YELLOW_CYC cycles, then ALL_RED.
// - ALL_RED: exactly ALL_RED_CYC cycles. Then GREEN with cur_dir<=target, cnt=0, switch_pulse=1 for that cycle.
// - Emergency during YELLOW/ALL_RED with emer_dir!=cur_dir: target<=emer_dir.
//   - Phase timing is unchanged; a yellow phase is never shortened.
// - Emergency during YELLOW/ALL_RED with emer_dir==cur_dir: target unchanged; the sequence completes.
// - traffic sampled only in GREEN. Demand arriving during YELLOW/ALL_RED does not alter target.
// STRUCTURE
// - traffic_pkg holds:
//   - light_t enum logic[1:0] {GREEN=2'b00, YELLOW=2'b01, RED=2'b10}
//   - phase_t enum {PH_GREEN, PH_YELLOW, PH_ALL_RED}
// - Sub-module traffic_rr_pick: combinational round-robin finder.
//   - Params: N_DIR. Inputs: req[N_DIR], cur[DIR_W]. Outputs: pick[DIR_W], found.
// - Top: state/counter/target registers plus light decode.
// TESTING (N_DIR=3, MIN=4, MAX=8, YELLOW=2, ALL_RED=1; cycle 0 = first edge after rst drops)
// - traffic=3'b001 held 50 cycles -> lights stay {RED,RED,GREEN}; switch_pulse never asserts.
// - traffic=3'b110 from cycle 0 -> dir0 GREEN cycles 0-3, YELLOW 4-5, ALL_RED 6; dir1 GREEN at 7 with switch_pulse=1.
// - traffic=3'b111 held -> each green lasts exactly 8 cycles, order 0,1,2,0. Every gap is 2 YELLOW + 1 ALL_RED.
// - emer_valid=1, emer_dir=2 at dir0 green cnt=1 -> YELLOW next cycle; dir2 GREEN after 3 more cycles.
//   - Also: emer_dir=0 at the same point -> dir0 stays green past cnt=7 with all traffic high.
// - emer_dir=3 with emer_valid=1 -> ignored; behaviour identical to the run without emergency.
// - rst=1 asserted during YELLOW -> next cycle dir0 GREEN, cnt=0, cur_dir=0, no switch_pulse.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encoding and controller phase type for the multi-direction light controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin finder: first requesting index after cur, wrapping, never cur itself.
module traffic_rr_pick #(
    parameter int N_DIR = 3,
    localparam int DIR_W = $clog2(N_DIR)
) (
    input  logic [N_DIR-1:0] req,
    input  logic [DIR_W-1:0] cur,
    output logic [DIR_W-1:0] pick,
    output logic             found
);

    logic [DIR_W-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            idx = DIR_W'((int'(cur) + k) % N_DIR);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-direction light controller: bounded greens, YELLOW then ALL_RED on every change, round-robin
// among busy directions, emergency pre-emption. Moore outputs only.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int N_DIR         = 3,
    parameter int MIN_GREEN_CYC = 4,
    parameter int MAX_GREEN_CYC = 8,
    parameter int YELLOW_CYC    = 2,
    parameter int ALL_RED_CYC   = 1,
    localparam int DIR_W        = $clog2(N_DIR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DIR-1:0]     traffic,
    input  logic                 emer_valid,
    input  logic [DIR_W-1:0]     emer_dir,
    output logic [2*N_DIR-1:0]   lights,
    output logic [DIR_W-1:0]     cur_dir,
    output logic                 switch_pulse
);

    localparam int CNT_TOP_A = (MAX_GREEN_CYC > YELLOW_CYC) ? MAX_GREEN_CYC : YELLOW_CYC;
    localparam int CNT_TOP   = (CNT_TOP_A > ALL_RED_CYC) ? CNT_TOP_A : ALL_RED_CYC;
    localparam int CNT_W     = (CNT_TOP < 2) ? 1 : $clog2(CNT_TOP);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_TOP - 1);
    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] RED_M1  = CNT_W'(ALL_RED_CYC - 1);

    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [DIR_W-1:0] target;
    logic [DIR_W-1:0] pick;
    logic             found;
    logic             emer_ok;
    logic             emer_other;

    traffic_rr_pick #(.N_DIR(N_DIR)) u_pick (
        .req   (traffic),
        .cur   (cur_dir),
        .pick  (pick),
        .found (found)
    );

    // Out-of-range emergency directions are dropped here so nothing downstream sees them.
    assign emer_ok    = emer_valid && (int'(emer_dir) < N_DIR);
    assign emer_other = emer_ok && (emer_dir != cur_dir);
    assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= PH_GREEN;
            cnt          <= '0;
            cur_dir      <= '0;
            target       <= '0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            case (phase)
                PH_GREEN: begin
                    if (emer_ok && !emer_other) begin
                        cnt <= cnt_inc;
                    end else if (emer_other) begin
                        target <= emer_dir;
                        phase  <= PH_YELLOW;
                        cnt    <= '0;
                    end else if (found && cnt >= MIN_M1 && (!traffic[cur_dir] || cnt >= MAX_M1)) begin
                        target <= pick;
                        phase  <= PH_YELLOW;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PH_YELLOW: begin
                    if (emer_other) target <= emer_dir;
                    if (cnt == YEL_M1) begin
                        phase <= PH_ALL_RED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    if (emer_other) target <= emer_dir;
                    if (cnt == RED_M1) begin
                        phase        <= PH_GREEN;
                        cnt          <= '0;
                        cur_dir      <= target;
                        switch_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_DIR; i++) begin
            lights[2*i +: 2] = RED;
            if (DIR_W'(i) == cur_dir) begin
                if (phase == PH_GREEN)       lights[2*i +: 2] = GREEN;
                else if (phase == PH_YELLOW) lights[2*i +: 2] = YELLOW;
            end
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed scenarios plus randomized traffic/emergency, checked every cycle against a timing model.
module tb_traffic_ctrl_multi;

    localparam int N   = 3;
    localparam int MIN = 4;
    localparam int MAX = 8;
    localparam int YEL = 2;
    localparam int AR  = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] traffic;
    logic         emer_valid;
    logic [1:0]   emer_dir;
    logic [5:0]   lights;
    logic [1:0]   cur_dir;
    logic         switch_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0=green 1=yellow 2=all-red, age = cycles already spent in the phase.
    int m_phase, m_dir, m_tgt, m_age;
    bit m_pulse;
    int pulse_cnt;

    always #5 clk = ~clk;

    traffic_ctrl_multi dut (
        .clk          (clk),
        .rst          (rst),
        .traffic      (traffic),
        .emer_valid   (emer_valid),
        .emer_dir     (emer_dir),
        .lights       (lights),
        .cur_dir      (cur_dir),
        .switch_pulse (switch_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model_lights();
        logic [5:0] v;
        v = 6'b101010;
        if (m_phase == 0)      v[2*m_dir +: 2] = 2'b00;
        else if (m_phase == 1) v[2*m_dir +: 2] = 2'b01;
        return v;
    endfunction

    task automatic model_step();
        bit eok;
        int p, d;
        int old_tgt;
        eok = emer_valid && (int'(emer_dir) < N);
        old_tgt = m_tgt;
        m_pulse = 0;
        if (rst) begin
            m_phase = 0; m_dir = 0; m_tgt = 0; m_age = 0;
            return;
        end
        if (m_phase == 0) begin
            p = -1;
            for (int k = 1; k < N; k++) begin
                d = (m_dir + k) % N;
                if (p < 0 && traffic[d]) p = d;
            end
            if (eok && int'(emer_dir) == m_dir) m_age++;
            else if (eok) begin m_tgt = emer_dir; m_phase = 1; m_age = 0; end
            else if (p >= 0 && m_age >= MIN - 1 && (!traffic[m_dir] || m_age >= MAX - 1)) begin
                m_tgt = p; m_phase = 1; m_age = 0;
            end else m_age++;
        end else begin
            if (eok && int'(emer_dir) != m_dir) m_tgt = emer_dir;
            if (m_age + 1 == ((m_phase == 1) ? YEL : AR)) begin
                m_age = 0;
                if (m_phase == 1) m_phase = 2;
                else begin m_phase = 0; m_dir = old_tgt; m_pulse = 1; end
            end else m_age++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (switch_pulse === 1'b1) pulse_cnt++;
        check("lights", 32'(lights), 32'(model_lights()));
        check("cur_dir", 32'(cur_dir), 32'(m_dir));
        check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; traffic = '0; emer_valid = 1'b0; emer_dir = '0;
        m_phase = 0; m_dir = 0; m_tgt = 0; m_age = 0; m_pulse = 0; pulse_cnt = 0;

        // Only dir0 busy: lights frozen, never a switch.
        do_reset();
        check("reset_lights", 32'(lights), 32'h28);
        traffic = 3'b001;
        repeat (50) tick();
        check("hold_lights", 32'(lights), 32'h28);
        check("hold_no_pulse", 32'(pulse_cnt), 32'd0);

        // Demand on 1 and 2 only: 4 green, 2 yellow, 1 all-red, dir1 green at sample 7.
        traffic = 3'b110;
        do_reset();
        repeat (4) tick();
        check("min_yellow", 32'(lights), 32'h29);
        repeat (2) tick();
        check("min_allred", 32'(lights), 32'h2a);
        tick();
        check("min_dir1", 32'(cur_dir), 32'd1);
        check("min_pulse", 32'(switch_pulse), 32'd1);

        // All busy: 8-cycle greens in order 0,1,2,0.
        traffic = 3'b111;
        do_reset();
        repeat (11) tick();
        check("max_dir1", 32'(cur_dir), 32'd1);
        check("max_pulse1", 32'(switch_pulse), 32'd1);
        repeat (11) tick();
        check("max_dir2", 32'(cur_dir), 32'd2);
        repeat (11) tick();
        check("max_dir0", 32'(cur_dir), 32'd0);
        check("max_pulse0", 32'(switch_pulse), 32'd1);

        // Emergency to dir2 at dir0 cnt=1.
        do_reset();
        tick();
        emer_valid = 1'b1; emer_dir = 2'd2;
        tick();
        check("emer_yellow", 32'(lights), 32'h29);
        repeat (3) tick();
        check("emer_dir2", 32'(cur_dir), 32'd2);
        check("emer_green2", 32'(lights), 32'h0a);
        emer_valid = 1'b0;

        // Emergency on the current direction suspends the max limit.
        do_reset();
        tick();
        emer_valid = 1'b1; emer_dir = 2'd0;
        repeat (12) tick();
        check("emer_hold", 32'(lights), 32'h28);
        emer_valid = 1'b0;
        repeat (10) tick();

        // Out-of-range emergency direction is ignored.
        traffic = 3'b110;
        emer_valid = 1'b1; emer_dir = 2'd3;
        do_reset();
        repeat (7) tick();
        check("bad_emer_dir1", 32'(cur_dir), 32'd1);
        check("bad_emer_pulse", 32'(switch_pulse), 32'd1);
        emer_valid = 1'b0;

        // Reset during YELLOW.
        traffic = 3'b111;
        do_reset();
        repeat (8) tick();
        check("pre_rst_yellow", 32'(lights), 32'h29);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_lights", 32'(lights), 32'h28);
        check("rst_dir", 32'(cur_dir), 32'd0);
        check("rst_pulse", 32'(switch_pulse), 32'd0);

        // Randomized traffic, emergencies (including invalid dir 3) and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) traffic = N'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                emer_valid = ($urandom_range(0, 2) == 0);
                emer_dir   = 2'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
